// File: rtl/mips_multicycle_control_if.sv
// Memory handshake between the multicycle controller and the Avalon-style memory port.
//   read        controller -> memory  read strobe
//   write       controller -> memory  write strobe
//   waitrequest memory -> controller  stall; a transfer completes on a cycle where it is low
interface mips_multicycle_control_if;
  logic read;
  logic write;
  logic waitrequest;

  modport master (
    output read,
    output write,
    input  waitrequest
  );

  modport slave (
    input  read,
    input  write,
    output waitrequest
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over an
// Avalon-style memory port and decodes the held instruction into datapath selects.
// Outputs are combinational on state + instr (+ waitrequest/alu_flag where a strobe is qualified).
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   mem (master)        read/write strobes out, waitrequest in
//   instr               instruction register contents
//   alu_flag            ALUResult[0], branch compare result
//   jr_target_zero      rs == 0, halt detect on JR
//   IorD .. MemtoReg    datapath selects and write strobes
//   active              high while running, low after halt
module mips_multicycle_control (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_control_if.master     mem,
  input  logic [31:0]                   instr,
  input  logic                          alu_flag,
  input  logic                          jr_target_zero,
  output logic                          IorD,
  output logic                          IRWrite,
  output logic                          PCWrite,
  output logic [1:0]                    PCSource,
  output logic                          ALUSrcA,
  output logic [1:0]                    ALUSrcB,
  output logic [4:0]                    ALUControl,
  output logic                          RegWrite,
  output logic [1:0]                    RegDst,
  output logic                          MemtoReg,
  output logic                          active
);

  localparam int unsigned OPC_W = 6;
  localparam int unsigned ST_W  = 4;

  // FSM states
  localparam logic [ST_W-1:0] S_RESET  = 4'd0;
  localparam logic [ST_W-1:0] S_FETCH  = 4'd1;
  localparam logic [ST_W-1:0] S_DECODE = 4'd2;
  localparam logic [ST_W-1:0] S_EXEC   = 4'd3;
  localparam logic [ST_W-1:0] S_MEMADR = 4'd4;
  localparam logic [ST_W-1:0] S_MEMRD  = 4'd5;
  localparam logic [ST_W-1:0] S_MEMWR  = 4'd6;
  localparam logic [ST_W-1:0] S_MEMWB  = 4'd7;
  localparam logic [ST_W-1:0] S_ALUWB  = 4'd8;
  localparam logic [ST_W-1:0] S_BRANCH = 4'd9;
  localparam logic [ST_W-1:0] S_JUMP   = 4'd10;
  localparam logic [ST_W-1:0] S_HALT   = 4'd11;

  // ALU operation codes
  localparam logic [4:0] ALU_AND   = 5'b00000;
  localparam logic [4:0] ALU_OR    = 5'b00001;
  localparam logic [4:0] ALU_ADD   = 5'b00010;
  localparam logic [4:0] ALU_XOR   = 5'b00011;
  localparam logic [4:0] ALU_SLL   = 5'b00100;
  localparam logic [4:0] ALU_SRL   = 5'b00101;
  localparam logic [4:0] ALU_SUB   = 5'b00110;
  localparam logic [4:0] ALU_SLT   = 5'b00111;
  localparam logic [4:0] ALU_SRA   = 5'b01000;
  localparam logic [4:0] ALU_SLTU  = 5'b01001;
  localparam logic [4:0] ALU_EQ    = 5'b01010;
  localparam logic [4:0] ALU_PASSB = 5'b01011;
  localparam logic [4:0] ALU_LINK  = 5'b01101;
  localparam logic [4:0] ALU_PASSA = 5'b01110;
  localparam logic [4:0] ALU_LEZ   = 5'b10000;
  localparam logic [4:0] ALU_JUMP  = 5'b10001;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_BLEZ  = 6'h06;
  localparam logic [OPC_W-1:0] OP_BGTZ  = 6'h07;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPC_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [OPC_W-1:0] FN_SLL  = 6'h00;
  localparam logic [OPC_W-1:0] FN_SRL  = 6'h02;
  localparam logic [OPC_W-1:0] FN_SRA  = 6'h03;
  localparam logic [OPC_W-1:0] FN_JR   = 6'h08;
  localparam logic [OPC_W-1:0] FN_ADD  = 6'h21;
  localparam logic [OPC_W-1:0] FN_SUB  = 6'h23;
  localparam logic [OPC_W-1:0] FN_AND  = 6'h24;
  localparam logic [OPC_W-1:0] FN_OR   = 6'h25;
  localparam logic [OPC_W-1:0] FN_XOR  = 6'h26;
  localparam logic [OPC_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [OPC_W-1:0] FN_SLTU = 6'h2B;

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_nxt;
  logic [OPC_W-1:0] opcode;
  logic [OPC_W-1:0] funct;
  logic             is_rtype;
  logic [4:0]       r_alu;
  logic             r_known;
  logic [4:0]       i_alu;
  logic             branch_inv;
  logic             unused_instr_bits;

  assign opcode   = instr[31:32-OPC_W];
  assign funct    = instr[OPC_W-1:0];
  assign is_rtype = (opcode == OP_RTYPE);

  // Register/immediate/shamt fields are consumed by the datapath, not here
  assign unused_instr_bits = ^instr[25:6];

  // R-type funct to ALU operation
  always_comb begin
    r_alu   = ALU_AND;
    r_known = 1'b1;
    case (funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_XOR:  r_alu = ALU_XOR;
      FN_SLT:  r_alu = ALU_SLT;
      FN_SLTU: r_alu = ALU_SLTU;
      FN_SLL:  r_alu = ALU_SLL;
      FN_SRL:  r_alu = ALU_SRL;
      FN_SRA:  r_alu = ALU_SRA;
      default: r_known = 1'b0;
    endcase
  end

  // I-type opcode to ALU operation; zero-extension for logical immediates lives in the datapath
  always_comb begin
    i_alu = ALU_ADD;
    case (opcode)
      OP_ADDIU: i_alu = ALU_ADD;
      OP_SLTI:  i_alu = ALU_SLT;
      OP_SLTIU: i_alu = ALU_SLTU;
      OP_ANDI:  i_alu = ALU_AND;
      OP_ORI:   i_alu = ALU_OR;
      OP_XORI:  i_alu = ALU_XOR;
      OP_LUI:   i_alu = ALU_PASSB;
      default:  i_alu = ALU_ADD;
    endcase
  end

  // BNE/BGTZ reuse the EQ/LEZ compare with the sense flipped
  assign branch_inv = (opcode == OP_BNE) || (opcode == OP_BGTZ);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Moore-style outputs
  always_comb begin
    state_nxt  = state;
    mem.read   = 1'b0;
    mem.write  = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSource   = 2'd0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'd0;
    ALUControl = ALU_AND;
    RegWrite   = 1'b0;
    RegDst     = 2'd0;
    MemtoReg   = 1'b0;
    active     = 1'b1;

    case (state)
      S_RESET: begin
        state_nxt = S_FETCH;
      end

      // PC + 4 computed every cycle; IR and PC only load on the completing cycle
      S_FETCH: begin
        mem.read   = 1'b1;
        ALUSrcB    = 2'd1;
        ALUControl = ALU_ADD;
        if (!mem.waitrequest) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      // Branch target precomputed into ALUOut while dispatching
      S_DECODE: begin
        ALUSrcB    = 2'd3;
        ALUControl = ALU_ADD;
        case (opcode)
          OP_RTYPE:                         state_nxt = (funct == FN_JR) ? S_JUMP : S_EXEC;
          OP_LW, OP_SW:                     state_nxt = S_MEMADR;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_nxt = S_BRANCH;
          OP_J, OP_JAL:                     state_nxt = S_JUMP;
          OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI:          state_nxt = S_EXEC;
          default:                          state_nxt = S_FETCH;
        endcase
      end

      // Unknown R-type funct retires as a NOP without reaching writeback
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (is_rtype) begin
          ALUSrcB    = 2'd0;
          ALUControl = r_alu;
          state_nxt  = r_known ? S_ALUWB : S_FETCH;
        end else begin
          ALUSrcB    = 2'd2;
          ALUControl = i_alu;
          state_nxt  = S_ALUWB;
        end
      end

      S_ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = is_rtype ? 2'd1 : 2'd0;
        state_nxt = S_FETCH;
      end

      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        ALUControl = ALU_ADD;
        state_nxt  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem.read = 1'b1;
        IorD     = 1'b1;
        if (!mem.waitrequest) begin
          state_nxt = S_MEMWB;
        end
      end

      S_MEMWR: begin
        mem.write = 1'b1;
        IorD      = 1'b1;
        if (!mem.waitrequest) begin
          state_nxt = S_FETCH;
        end
      end

      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        state_nxt = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd0;
        ALUControl = ((opcode == OP_BEQ) || (opcode == OP_BNE)) ? ALU_EQ : ALU_LEZ;
        PCWrite    = alu_flag ^ branch_inv;
        PCSource   = 2'd1;
        state_nxt  = S_FETCH;
      end

      // JR to address zero is the halt convention
      S_JUMP: begin
        PCWrite = 1'b1;
        if (is_rtype) begin
          ALUSrcA    = 1'b1;
          ALUControl = ALU_PASSA;
          PCSource   = 2'd0;
          state_nxt  = jr_target_zero ? S_HALT : S_FETCH;
        end else begin
          PCSource  = 2'd2;
          state_nxt = S_FETCH;
          if (opcode == OP_JAL) begin
            RegWrite   = 1'b1;
            RegDst     = 2'd2;
            ALUControl = ALU_LINK;
          end else begin
            ALUControl = ALU_JUMP;
          end
        end
      end

      S_HALT: begin
        active = 1'b0;
      end

      default: begin
        state_nxt = S_RESET;
      end
    endcase
  end

endmodule
